simple_proc_ctrl: RTL and testbench

Multi-cycle control unit for the 8-bit simple processor. It fetches 8-bit instructions over a req/ack handshake, decodes them, and sequences a 4x8 register file and 8-bit add/sub datapath (3-bit and 5-bit sign extension included). It also handles PC-relative branches and halt. It sits between instruction memory and the processor datapath, and exposes a debug register read port for benches.

---
 rtl/proc_pkg.sv | 34 +++
 rtl/proc_regfile.sv | 44 ++++
 rtl/simple_proc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_simple_proc_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// +----------------------------------------------------------------------+
// | proc_pkg                                                             |
// | Shared widths, opcode constants and FSM state type for the 8-bit     |
// | simple processor control unit.                                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package proc_pkg;

  localparam int DATA_W   = 8;
  localparam int REG_AW   = 2;
  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(1);

  // Major opcode field ir[7:6]
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_CTL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/proc_regfile.sv
// +----------------------------------------------------------------------+
// | proc_regfile                                                         |
// | 4x8 register file: two combinational operand read ports, one         |
// | combinational debug read port, one synchronous write port.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module proc_regfile
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  input  logic [REG_AW-1:0] dbg_sel_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Register storage: cleared on reset, single write per clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = regs_q[raddr_a_i];
  assign rdata_b_o  = regs_q[raddr_b_i];
  assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

`default_nettype wire

// File: rtl/simple_proc_ctrl.sv
// +----------------------------------------------------------------------+
// | simple_proc_ctrl                                                     |
// | Multi-cycle control unit: fetch over req/ack, decode, execute        |
// | add/sub/addi, PC-relative branch-if-r0-zero, halt.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module simple_proc_ctrl
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              imem_req_o,
  output logic [DATA_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic [DATA_W-1:0] pc_out_o,
  input  logic [REG_AW-1:0] dbg_sel_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  state_e            state_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] res_q;
  logic              zero_q;
  logic              imem_req_q;
  logic              busy_q;
  logic              halted_q;

  logic [1:0]        w_op;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_raddr_a;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;
  logic [DATA_W-1:0] w_sext3;
  logic [DATA_W-1:0] w_sext5;
  logic [DATA_W-1:0] w_pc_plus1;
  logic [DATA_W-1:0] w_pc_branch;
  logic              w_rf_we;
  logic [DATA_W-1:0] res_d;

  assign w_op = ir_q[7:6];
  assign w_rd = ir_q[5:4];
  assign w_rs = ir_q[3:2];

  // Control instructions test r0, so port A is steered to r0 for them
  assign w_raddr_a = (w_op == OP_CTL) ? '0 : w_rd;

  assign w_sext3     = {{(DATA_W-3){ir_q[2]}}, ir_q[2:0]};
  assign w_sext5     = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
  assign w_pc_plus1  = pc_q + PC_STEP;
  assign w_pc_branch = pc_q + w_sext5;

  // Destination is written only on the edge that leaves WB
  assign w_rf_we = (state_q == WB);

  proc_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (w_rf_we),
    .waddr_i    (w_rd),
    .wdata_i    (res_q),
    .raddr_a_i  (w_raddr_a),
    .raddr_b_i  (w_rs),
    .dbg_sel_i  (dbg_sel_i),
    .rdata_a_o  (w_rdata_a),
    .rdata_b_o  (w_rdata_b),
    .dbg_data_o (dbg_data_o)
  );

  // ALU result from the operands latched in DECODE
  always_comb begin
    res_d = opa_q + opb_q;
    case (w_op)
      OP_SUB:  res_d = opa_q - opb_q;
      OP_ADDI: res_d = opa_q + w_sext3;
      default: res_d = opa_q + opb_q;
    endcase
  end

  // Instruction sequencer with registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      imem_req_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack_i) begin
            ir_q       <= imem_rdata_i;
            imem_req_q <= 1'b0;
            state_q    <= DECODE;
          end
        end
        DECODE: begin
          opa_q   <= w_rdata_a;
          opb_q   <= w_rdata_b;
          zero_q  <= (w_rdata_a == '0);
          state_q <= EXEC;
        end
        EXEC: begin
          if (w_op != OP_CTL) begin
            res_q   <= res_d;
            state_q <= WB;
          end else if (ir_q[5]) begin
            state_q  <= HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            pc_q       <= zero_q ? w_pc_branch : w_pc_plus1;
            imem_req_q <= 1'b1;
            state_q    <= FETCH;
          end
        end
        WB: begin
          pc_q       <= w_pc_plus1;
          imem_req_q <= 1'b1;
          state_q    <= FETCH;
        end
        HALTED: begin
          if (start_i) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = pc_q;
  assign busy_o      = busy_q;
  assign halted_o    = halted_q;
  assign pc_out_o    = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_simple_proc_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_simple_proc_ctrl                                                  |
// | Directed programs against an instruction-memory model; expected      |
// | fetch addresses/gaps are queued and checked by a fetch monitor.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_simple_proc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       busy;
  logic       halted;
  logic [7:0] pc_out;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] mem [256];
  int         wait_n = 0;
  int         wcnt = 0;
  logic       stray_ack = 1'b0;
  bit         noisy = 1'b0;

  typedef struct {
    logic [7:0] addr;
    int         gap;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int         last_hs = 0;
  logic       prev_wait = 1'b0;
  logic [7:0] prev_addr = 8'h00;

  simple_proc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ack_i   (imem_ack),
    .imem_rdata_i (imem_rdata),
    .busy_o       (busy),
    .halted_o     (halted),
    .pc_out_o     (pc_out),
    .dbg_sel_i    (dbg_sel),
    .dbg_data_o   (dbg_data)
  );

  always #5 clk = ~clk;

  // Memory model: ack after wait_n stall cycles; stray ack only when no request
  assign imem_ack   = imem_req ? (wcnt == wait_n) : stray_ack;
  assign imem_rdata = mem[imem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fetch monitor: address stability while stalled, and queued fetch order/timing
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && prev_wait) check("addr_stable", imem_addr, prev_addr);
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (imem_req && imem_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got addr %02h, expected no fetch", imem_addr);
        end else begin
          mon_e = exp_q.pop_front();
          check("fetch_addr", imem_addr, mon_e.addr);
          if (mon_e.gap > 0) check("fetch_gap", cyc - last_hs, mon_e.gap);
        end
        last_hs = cyc;
      end
    end else begin
      prev_wait = 1'b0;
    end
  end

  task automatic expect_fetch(input logic [7:0] a, input int gap);
    exp_t e;
    e.addr = a;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reg(input int idx, input int exp);
    dbg_sel = idx[1:0];
    #1;
    check($sformatf("r%0d", idx), dbg_data, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_imem_req"}, imem_req, 0);
    check({tag, "_pc"}, pc_out, 0);
  endtask

  task automatic wait_halt(input bit chk_timing);
    int n;
    n = 0;
    while (!halted && n < 500) begin
      @(negedge clk);
      if (noisy) begin
        start     = busy;
        stray_ack = busy && !imem_req;
      end
      n++;
    end
    start = 1'b0;
    stray_ack = 1'b0;
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout: got halted=0 after %0d cycles, expected halted=1", n);
    end else if (chk_timing) begin
      check("halt_latency", cyc - last_hs, 3);
    end
    check("fetch_q_drained", exp_q.size(), 0);
  endtask

  task automatic arith_program(input int gap);
    clear_mem();
    mem[0] = 8'h93; mem[1] = 8'hA7; mem[2] = 8'h18; mem[3] = 8'h74; mem[4] = 8'hE0;
    expect_fetch(8'h00, 0);
    for (int a = 1; a <= 4; a++) expect_fetch(a[7:0], gap);
    pulse_start();
    wait_halt(1'b1);
    check_reg(0, 8'h00); check_reg(1, 8'h02); check_reg(2, 8'hFF); check_reg(3, 8'hFE);
    check("arith_halted", halted, 1);
    check("arith_pc", pc_out, 8'h04);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int n;
    clear_mem();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    for (int i = 0; i < 4; i++) check_reg(i, 0);
    rst = 1'b0;

    // Arithmetic, zero-wait then 3-wait memory
    wait_n = 0;
    arith_program(4);
    do_reset();
    wait_n = 3;
    arith_program(7);

    // Branch taken
    do_reset();
    wait_n = 0;
    clear_mem();
    mem[0] = 8'hC2;
    expect_fetch(8'h00, 0); expect_fetch(8'h02, 3);
    pulse_start();
    wait_halt(1'b1);
    check("brz_taken_pc", pc_out, 8'h02);

    // Branch not taken after r0 = 1
    do_reset();
    clear_mem();
    mem[0] = 8'h81; mem[1] = 8'hC2;
    expect_fetch(8'h00, 0); expect_fetch(8'h01, 4); expect_fetch(8'h02, 3);
    pulse_start();
    wait_halt(1'b1);
    check("brz_fall_pc", pc_out, 8'h02);
    check_reg(0, 8'h01);

    // Negative branch offset
    do_reset();
    clear_mem();
    mem[0] = 8'hC5; mem[5] = 8'hDF;
    expect_fetch(8'h00, 0); expect_fetch(8'h05, 3); expect_fetch(8'h04, 3);
    pulse_start();
    wait_halt(1'b1);
    check("brz_neg_pc", pc_out, 8'h04);

    // Reset asserted during WB of ADD r2 = r2 + r1
    do_reset();
    clear_mem();
    mem[0] = 8'h93; mem[1] = 8'h24;
    expect_fetch(8'h00, 0); expect_fetch(8'h01, 4);
    pulse_start();
    n = 0;
    while (!(imem_req && imem_ack && imem_addr == 8'h01) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_add_fetch", (n < 100) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_reset_outputs("midwb");
    check_reg(2, 8'h00);
    check_reg(1, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    expect_fetch(8'h00, 0); expect_fetch(8'h01, 4); expect_fetch(8'h02, 4);
    pulse_start();
    wait_halt(1'b1);
    check_reg(1, 8'h03);
    check_reg(2, 8'h03);

    // Stray start/ack while busy, then restart from HALTED
    do_reset();
    clear_mem();
    mem[0] = 8'h93; mem[1] = 8'hE0;
    noisy = 1'b1;
    expect_fetch(8'h00, 0); expect_fetch(8'h01, 4);
    pulse_start();
    wait_halt(1'b1);
    check_reg(1, 8'h03);
    check("noisy_pc", pc_out, 8'h01);
    expect_fetch(8'h00, 0); expect_fetch(8'h01, 4);
    pulse_start();
    wait_halt(1'b1);
    noisy = 1'b0;
    check_reg(1, 8'h06);
    check("restart_pc", pc_out, 8'h01);

    // pc wrap from WB at 0xFF
    do_reset();
    clear_mem();
    mem[0] = 8'hDF; mem[8'hFF] = 8'h81; mem[1] = 8'hE0;
    expect_fetch(8'h00, 0); expect_fetch(8'hFF, 3); expect_fetch(8'h00, 4); expect_fetch(8'h01, 3);
    pulse_start();
    wait_halt(1'b1);
    check("wrap_pc", pc_out, 8'h01);
    check_reg(0, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
